// File: rtl/tlul_arb_m1.sv
// M:1 TL-UL host arbiter: round-robin A-channel grant with stall locking and an
// in-order routing FIFO that steers each D response back to its requesting host.
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_arb_m1_chk (
  input logic clk_i,
  input logic rst_i,
  input logic locked,
  input logic lock_valid
);
  // A locked host must keep its request up until it is accepted.
  locked_host_holds_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    locked |-> lock_valid);
endmodule

module tlul_arb_m1 #(
  parameter int M = 2,
  parameter int MaxOutstanding = 4,
  localparam int IdxW = $clog2(M),
  localparam int CntW = $clog2(MaxOutstanding) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_h2d_i [M],
  output tlul_pkg::tl_d2h_t tl_d2h_o [M],
  output tlul_pkg::tl_h2d_t tl_h2d_o,
  input  tlul_pkg::tl_d2h_t tl_d2h_i,
  output logic              busy_o,
  output logic [CntW-1:0]   outstanding_o,
  output logic              spurious_o
);
  localparam int PtrW = $clog2(MaxOutstanding);

  logic [IdxW-1:0] rr_ptr_r;
  logic            locked_r;
  logic [IdxW-1:0] lock_idx_r;
  logic [IdxW-1:0] fifo_r [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_r;
  logic [PtrW-1:0] rd_ptr_r;
  logic [CntW-1:0] count_r;
  logic            spurious_r;

  logic [IdxW-1:0] gnt_s;
  logic            gnt_valid_s;
  logic [IdxW-1:0] rr_next_s;
  logic            full_s;
  logic            have_s;
  logic [IdxW-1:0] head_s;
  logic            a_valid_fwd_s;
  logic            a_hs_s;
  logic            a_stall_s;
  logic            host_a_ready_s;
  logic            d_ready_fwd_s;
  logic            d_valid_route_s;
  logic            pop_s;
  logic            spur_s;
  logic [CntW-1:0] count_next_s;
  logic            lock_valid_s;
  tlul_pkg::tl_h2d_t fwd_s;

  // Grant selection: held host while locked, otherwise first valid host from rr_ptr.
  always_comb begin
    int cand;
    gnt_s = '0;
    gnt_valid_s = 1'b0;
    cand = 0;
    if (locked_r) begin
      gnt_s = lock_idx_r;
      gnt_valid_s = 1'b1;
    end else begin
      // Descending scan so the lowest rotation offset is written last and wins.
      for (int i = M - 1; i >= 0; i--) begin
        cand = (int'(rr_ptr_r) + i) % M;
        gnt_s = tl_h2d_i[cand].a_valid ? IdxW'(cand) : gnt_s;
        gnt_valid_s = tl_h2d_i[cand].a_valid ? 1'b1 : gnt_valid_s;
      end
    end
  end

  assign rr_next_s = (gnt_s == IdxW'(M - 1)) ? '0 : gnt_s + IdxW'(1);
  assign full_s    = (count_r == CntW'(MaxOutstanding));
  assign have_s    = (count_r != '0);
  assign head_s    = fifo_r[rd_ptr_r];
  assign lock_valid_s = tl_h2d_i[lock_idx_r].a_valid;

  // Handshake and routing qualifiers; everything is gated off while in reset.
  always_comb begin
    a_valid_fwd_s   = !rst_i && gnt_valid_s && !full_s && tl_h2d_i[gnt_s].a_valid;
    host_a_ready_s  = !rst_i && gnt_valid_s && !full_s && tl_d2h_i.a_ready;
    a_hs_s          = a_valid_fwd_s && tl_d2h_i.a_ready;
    a_stall_s       = a_valid_fwd_s && !tl_d2h_i.a_ready;
    d_valid_route_s = !rst_i && have_s && tl_d2h_i.d_valid;
    if (rst_i) begin
      d_ready_fwd_s = 1'b0;
    end else if (have_s) begin
      d_ready_fwd_s = tl_h2d_i[head_s].d_ready;
    end else begin
      // Nothing in flight: any response is spurious and is drained.
      d_ready_fwd_s = 1'b1;
    end
    pop_s  = have_s && tl_d2h_i.d_valid && d_ready_fwd_s;
    spur_s = !have_s && tl_d2h_i.d_valid;
  end

  // Occupancy update: push and pop in the same cycle cancel out.
  always_comb begin
    case ({a_hs_s, pop_s})
      2'b10:   count_next_s = count_r + CntW'(1);
      2'b01:   count_next_s = count_r - CntW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Downstream request: granted host's payload with qualified valid/ready.
  always_comb begin
    fwd_s = tl_h2d_i[gnt_s];
    fwd_s.a_valid = a_valid_fwd_s;
    fwd_s.d_ready = d_ready_fwd_s;
  end

  assign tl_h2d_o = fwd_s;

  // Host responses: D payload broadcast, d_valid only to head, a_ready only to grant.
  always_comb begin
    for (int h = 0; h < M; h++) begin
      tl_d2h_o[h] = tl_d2h_i;
      tl_d2h_o[h].d_valid = d_valid_route_s && (head_s == IdxW'(h));
      tl_d2h_o[h].a_ready = host_a_ready_s && (gnt_s == IdxW'(h));
    end
  end

  // Arbiter state, routing FIFO, occupancy and sticky spurious flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_r   <= '0;
      locked_r   <= 1'b0;
      lock_idx_r <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      spurious_r <= 1'b0;
      for (int k = 0; k < MaxOutstanding; k++) begin
        fifo_r[k] <= '0;
      end
    end else begin
      if (a_hs_s) begin
        fifo_r[wr_ptr_r] <= gnt_s;
        wr_ptr_r <= wr_ptr_r + PtrW'(1);
        rr_ptr_r <= rr_next_s;
        locked_r <= 1'b0;
      end else if (a_stall_s) begin
        locked_r   <= 1'b1;
        lock_idx_r <= gnt_s;
      end else begin
        locked_r <= locked_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (spur_s) begin
        spurious_r <= 1'b1;
      end else begin
        spurious_r <= spurious_r;
      end
      count_r <= count_next_s;
    end
  end

  assign outstanding_o = count_r;
  assign busy_o        = (count_r != '0);
  assign spurious_o    = spurious_r;

  tlul_arb_m1_chk u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .locked     (locked_r),
    .lock_valid (lock_valid_s)
  );
endmodule

// File: tb/tb_tlul_arb_m1.sv
// Directed bench for tlul_arb_m1: host/target models plus queue scoreboards
// checked by a negedge monitor, with direct checks for lock, full, spurious and reset.
module tb_tlul_arb_m1;
  import tlul_pkg::*;

  logic clk;
  logic rst_i;
  tl_h2d_t host_h2d [2];
  tl_d2h_t host_d2h [2];
  tl_h2d_t dn_h2d;
  tl_d2h_t tgt_d;
  logic       busy;
  logic [2:0] outstanding;
  logic       spurious;

  tlul_arb_m1 #(.M(2), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tl_h2d_i(host_h2d), .tl_d2h_o(host_d2h),
    .tl_h2d_o(dn_h2d), .tl_d2h_i(tgt_d),
    .busy_o(busy), .outstanding_o(outstanding), .spurious_o(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int peak = 0;
  int hs_cyc [$];

  logic [31:0] host_q [2][$];
  logic [31:0] exp_d [2][$];
  logic [31:0] exp_a [$];
  logic [31:0] tgt_q [$];
  logic tgt_a_ready = 1'b0;
  logic tgt_d_en = 1'b1;
  logic tgt_spur = 1'b0;
  logic dn_a_hs = 1'b0;
  logic dn_d_hs = 1'b0;
  logic [31:0] dn_a_addr = 32'd0;
  logic host_a_hs [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on every downstream A handshake and host D handshake.
  always @(negedge clk) begin
    cyc++;
    if (int'(outstanding) > peak) peak = int'(outstanding);
    dn_a_hs = dn_h2d.a_valid && tgt_d.a_ready;
    dn_d_hs = tgt_d.d_valid && dn_h2d.d_ready;
    dn_a_addr = dn_h2d.a_address;
    if (dn_a_hs) begin
      hs_cyc.push_back(cyc);
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected: got addr 0x%0h expected none", dn_a_addr);
      end else begin
        check("a_order", dn_a_addr, exp_a.pop_front());
      end
    end
    for (int h = 0; h < 2; h++) begin
      host_a_hs[h] = host_h2d[h].a_valid && host_d2h[h].a_ready;
      if (host_d2h[h].d_valid && host_h2d[h].d_ready) begin
        if (exp_d[h].size() == 0) begin
          checks++; failures++;
          $display("FAIL d_unexpected host%0d: got data 0x%0h expected none", h, host_d2h[h].d_data);
        end else begin
          check($sformatf("d_route_h%0d", h), host_d2h[h].d_data, exp_d[h].pop_front());
        end
      end
    end
  end

  // Host and target models update their drives just after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int h = 0; h < 2; h++) begin
      if (host_a_hs[h] && host_q[h].size() > 0) void'(host_q[h].pop_front());
      host_h2d[h] = '0;
      host_h2d[h].d_ready = 1'b1;
      host_h2d[h].a_opcode = 3'd4;
      host_h2d[h].a_source = 8'(h);
      host_h2d[h].a_valid = (host_q[h].size() > 0);
      host_h2d[h].a_address = (host_q[h].size() > 0) ? host_q[h][0] : 32'd0;
    end
    if (dn_a_hs) tgt_q.push_back(dn_a_addr);
    if (dn_d_hs && tgt_q.size() > 0) void'(tgt_q.pop_front());
    host_a_hs[0] = 1'b0; host_a_hs[1] = 1'b0;
    dn_a_hs = 1'b0; dn_d_hs = 1'b0;
    tgt_d = '0;
    tgt_d.a_ready = tgt_a_ready;
    tgt_d.d_valid = (tgt_d_en && tgt_q.size() > 0) || tgt_spur;
    tgt_d.d_data = (tgt_q.size() > 0) ? tgt_q[0] : 32'hDEAD_0000;
  end

  task automatic req(input int h, input logic [31:0] addr);
    host_q[h].push_back(addr);
    exp_d[h].push_back(addr);
  endtask

  task automatic clear_model();
    host_q[0].delete(); host_q[1].delete();
    exp_d[0].delete(); exp_d[1].delete();
    exp_a.delete(); tgt_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    clear_model();
    tgt_spur = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = host_q[0].size() == 0 && host_q[1].size() == 0 && exp_a.size() == 0 &&
             exp_d[0].size() == 0 && exp_d[1].size() == 0 && tgt_q.size() == 0 &&
             outstanding == 3'd0;
    end
    check({name, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic wait_count(input string name, input logic [2:0] n);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = (outstanding == n);
    end
    check({name, "_count_reached"}, 32'(done), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    tgt_d = '0;
    host_h2d[0] = '0; host_h2d[1] = '0;
    repeat (2) @(negedge clk);
    tgt_d.a_ready = 1'b1;
    #1;
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spurious", 32'(spurious), 32'd0);
    check("rst_dn_a_valid", 32'(dn_h2d.a_valid), 32'd0);
    check("rst_h0_a_ready", 32'(host_d2h[0].a_ready), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Host0 alone, three gets back to back.
    tgt_a_ready = 1'b1; tgt_d_en = 1'b1;
    @(negedge clk);
    peak = 0; hs_cyc.delete();
    req(0, 32'h100); req(0, 32'h104); req(0, 32'h108);
    exp_a.push_back(32'h100); exp_a.push_back(32'h104); exp_a.push_back(32'h108);
    wait_idle("t1");
    check("t1_hs_count", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) check("t1_consecutive", 32'(hs_cyc[2] - hs_cyc[0]), 32'd2);
    check("t1_peak_in_range", 32'(peak >= 1 && peak <= 3), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Two hosts always valid: grants alternate 0,1,0,1.
    do_reset();
    req(0, 32'h200); req(1, 32'h204); req(0, 32'h208); req(1, 32'h20C);
    exp_a.push_back(32'h200); exp_a.push_back(32'h204);
    exp_a.push_back(32'h208); exp_a.push_back(32'h20C);
    wait_idle("t2");

    // Grant lock: rr_ptr points at host1, host0 stalled, host1 arrives mid-stall.
    do_reset();
    req(0, 32'h2F0); exp_a.push_back(32'h2F0);
    wait_idle("t3_pre");
    tgt_a_ready = 1'b0;
    req(0, 32'h300); exp_a.push_back(32'h300);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_lock_addr", dn_h2d.a_address, 32'h300);
      check("t3_lock_valid", 32'(dn_h2d.a_valid), 32'd1);
      if (k == 0) begin
        req(1, 32'h304); exp_a.push_back(32'h304);
      end
    end
    tgt_a_ready = 1'b1;
    wait_idle("t3");

    // Full routing FIFO blocks the 5th request until a response pops.
    do_reset();
    tgt_d_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req(0, 32'h400 + 32'(4 * k)); exp_a.push_back(32'h400 + 32'(4 * k));
    end
    wait_count("t4", 3'd4);
    @(negedge clk);
    check("t4_full_count", 32'(outstanding), 32'd4);
    check("t4_full_a_valid", 32'(dn_h2d.a_valid), 32'd0);
    check("t4_full_a_ready", 32'(host_d2h[0].a_ready), 32'd0);
    check("t4_full_busy", 32'(busy), 32'd1);
    tgt_d_en = 1'b1;
    @(negedge clk);
    check("t4_pop_d_valid", 32'(host_d2h[0].d_valid), 32'd1);
    check("t4_pop_a_still_blocked", 32'(dn_h2d.a_valid), 32'd0);
    @(negedge clk);
    check("t4_fifth_a_valid", 32'(dn_h2d.a_valid), 32'd1);
    check("t4_fifth_addr", dn_h2d.a_address, 32'h410);
    check("t4_after_pop_count", 32'(outstanding), 32'd3);
    wait_idle("t4");

    // Spurious response with nothing outstanding.
    do_reset();
    tgt_spur = 1'b1;
    @(negedge clk);
    check("t5_spur_d_ready", 32'(dn_h2d.d_ready), 32'd1);
    check("t5_spur_h0_d_valid", 32'(host_d2h[0].d_valid), 32'd0);
    check("t5_spur_h1_d_valid", 32'(host_d2h[1].d_valid), 32'd0);
    tgt_spur = 1'b0;
    @(negedge clk);
    check("t5_spur_set", 32'(spurious), 32'd1);
    repeat (3) @(negedge clk);
    check("t5_spur_sticky", 32'(spurious), 32'd1);
    do_reset();
    check("t5_spur_cleared", 32'(spurious), 32'd0);

    // Reset with two requests in flight, then round-robin restarts at host0.
    tgt_d_en = 1'b0;
    req(0, 32'h500); req(0, 32'h504);
    exp_a.push_back(32'h500); exp_a.push_back(32'h504);
    wait_count("t6", 3'd2);
    @(negedge clk);
    rst_i = 1'b1;
    tgt_d.d_valid = 1'b1; tgt_d.a_ready = 1'b1;
    host_h2d[1].a_valid = 1'b1;
    #1;
    check("t6_rst_count", 32'(outstanding), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_h0_d_valid", 32'(host_d2h[0].d_valid), 32'd0);
    check("t6_rst_h1_a_ready", 32'(host_d2h[1].a_ready), 32'd0);
    check("t6_rst_dn_a_valid", 32'(dn_h2d.a_valid), 32'd0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    tgt_d_en = 1'b1;
    req(1, 32'h604); req(0, 32'h600);
    exp_a.push_back(32'h600); exp_a.push_back(32'h604);
    wait_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tlul_arb_m1.md
Name: tlul_arb_m1

Overview:
M:1 TL-UL host arbiter that shares one downstream target, such as the accelerator fan-out socket, between several hosts (CPU, DMA, debug). It round-robins A-channel requests with grant locking and records the granted host index in a response-routing FIFO. Each D-channel response returns to the host that issued the matching request. Downstream targets answer in request order, one response per request.

Parameters:
M, 2, number of upstream hosts (2..8)
MaxOutstanding, 4, depth of the routing FIFO, i.e. max requests in flight (power of 2, >=2)
IdxW, $clog2(M) (localparam), host index width
CntW, $clog2(MaxOutstanding)+1 (localparam), outstanding-count width

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous, active-high reset
tl_h2d_i  input  tlul_pkg::tl_h2d_t [M]  host-side requests
tl_d2h_o  output  tlul_pkg::tl_d2h_t [M]  host-side responses
tl_h2d_o  output  tlul_pkg::tl_h2d_t  request to shared target
tl_d2h_i  input  tlul_pkg::tl_d2h_t  response from shared target
busy_o  output  1  high when any request is outstanding (count != 0)
outstanding_o  output  CntW  current routing-FIFO occupancy
spurious_o  output  1  sticky: a D response arrived with no outstanding request

Behaviour:
- Reset (async, rst_i=1):
  - rr_ptr=0, locked=0, lock_idx=0, FIFO ptrs=0, count=0, spurious_o=0.
  - Every output valid and ready is 0 while in reset.
- Arbitration, combinational from registered state:
  - If locked=1, gnt=lock_idx.
  - Otherwise gnt = first host with a_valid, searching rr_ptr, rr_ptr+1, ... mod M.
  - No host valid -> no grant.
- A forwarding, zero added latency:
  - tl_h2d_o = tl_h2d_i[gnt], with a_valid forced to 0 when count==MaxOutstanding or there is no grant.
  - tl_d2h_o[gnt].a_ready = tl_d2h_i.a_ready && count!=MaxOutstanding. All other hosts see a_ready=0.
- Grant lock:
  - If the forwarded a_valid=1 and target a_ready=0, set locked=1 and lock_idx=gnt. This keeps the A payload stable across stalls.
  - Cleared on the accepting handshake.
- A handshake (forwarded a_valid && a_ready):
  - Push gnt into the FIFO, set rr_ptr=(gnt+1) mod M, clear locked.
- D routing:
  - head = FIFO[rd_ptr].
  - If count!=0: tl_d2h_o[head] = tl_d2h_i (all D fields). d_valid to every other host is 0. tl_h2d_o.d_ready = tl_h2d_i[head].d_ready.
  - D handshake pops the FIFO.
  - Non-head hosts still receive D payload fields, but d_valid=0.
- Spurious response: if count==0 and tl_d2h_i.d_valid=1:
  - d_ready to target = 1 (response discarded); no host sees d_valid.
  - spurious_o set; it clears only on reset.
- Counter: count += push - pop, so simultaneous push and pop leaves it unchanged.
  - Full gating uses registered count: when full, a pop in cycle N allows a push no earlier than cycle N+1.
  - Pointers wrap mod MaxOutstanding.
  - outstanding_o = count; busy_o = (count!=0).
- Host behaviour: a host deasserting a_valid while locked is a protocol violation. Behaviour is undefined; an SVA assertion flags it.
- Hosts' D-channel d_ready is consumed only for the head host.

Test Plan:
- Host0 alone sends 3 gets, target a_ready=1, responses one cycle later -> 3 A handshakes on consecutive cycles; each D goes only to host0; outstanding_o peaks at up to 3, returns to 0.
- Hosts 0 and 1 assert a_valid continuously, target always ready -> grants alternate 0,1,0,1; rr_ptr toggles each handshake; D responses go to host 0,1,0,1 in order.
- Host0 valid with target a_ready=0 for 4 cycles, host1 raises valid in cycle 2 -> gnt stays 0 (locked), tl_h2d_o payload constant; host0 accepted cycle 5, host1 granted next.
- Target withholds d_valid while 4 requests accepted (MaxOutstanding=4) -> 5th request sees a_ready=0, forwarded a_valid=0; first D pop frees a slot, 5th accepted the following cycle.
- Target raises d_valid with count=0 -> d_ready=1 to target, no host d_valid, spurious_o=1 and stays 1 until rst_i.
- Assert rst_i mid-traffic with 2 outstanding -> immediately count=0, busy_o=0, all host d_valid/a_ready=0; after release, fresh round-robin starts at host0.
